// File: rtl/mu_buffer_sequencer.sv
// -----------------------------------------------------------------------------
// mu_buffer_sequencer
//
// Purpose
//   Sequences one 8-lane x SIZE-deep mu circular buffer that feeds one PE.
//   It sweeps every buffer row for a run-time number of passes. Rows are
//   offered to the PE over a valid/ready handshake, with first/last-row
//   framing flags. The block drives the buffer's read_en and keeps a mirror of
//   the buffer's read pointer in row_idx.
//
//   An abort does not reset the buffer. Instead, the block drains the buffer's
//   read pointer forward until it reaches row 0 again. This keeps the buffer
//   and the sequencer aligned for the next run.
//
// Handshake
//   pe_valid is high for every cycle in RUN. A row transfers (a "fire") on any
//   rising edge where pe_valid && pe_ready is high. buf_read_en is raised in
//   that same cycle, so the buffer advances with the transfer. The block never
//   reads ahead of the PE.
//
// Ports
//   clk          in   1       clock; all state updates on the rising edge
//   rst          in   1       asynchronous, active-high reset (shared with buffer)
//   start        in   1       begin a run; sampled in IDLE only
//   cfg_passes   in   PASS_W  number of full sweeps; latched on accepted start
//   abort        in   1       stop the run; sampled in RUN only
//   pe_ready     in   1       PE accepts the current row
//   pe_valid     out  1       current row is valid for the PE
//   buf_read_en  out  1       buffer read_en; advances the buffer read pointer
//   row_idx      out  ROW_W   mirror of the buffer read pointer
//   pass_idx     out  PASS_W  current pass number, 0-based
//   first_row    out  1       pe_valid && row_idx == 0
//   last_row     out  1       pe_valid && row_idx == SIZE-1
//   final_beat   out  1       last_row && pass_idx == passes_q-1
//   busy         out  1       state is RUN or DRAIN
//   done         out  1       one-cycle pulse in DONE
//   aborted      out  1       qualified by done; 1 = run ended by abort
//   dbg_state    out  2       current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
// -----------------------------------------------------------------------------
module mu_buffer_sequencer #(
    parameter int SIZE   = 8,
    parameter int ROW_W  = $clog2(SIZE),
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              abort,
    input  logic              pe_ready,
    output logic              pe_valid,
    output logic              buf_read_en,
    output logic [ROW_W-1:0]  row_idx,
    output logic [PASS_W-1:0] pass_idx,
    output logic              first_row,
    output logic              last_row,
    output logic              final_beat,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [PASS_W-1:0] r_pass;
    logic [PASS_W-1:0] r_passes;
    logic              r_aborted;

    state_t            w_state_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [PASS_W-1:0] w_pass_nxt;
    logic [PASS_W-1:0] w_passes_nxt;
    logic              w_aborted_nxt;
    logic              w_read_en;

    logic              w_pe_valid;
    logic              w_fire;
    logic [ROW_W-1:0]  w_row_inc;
    logic              w_row_wrap;
    logic              w_last_row;
    logic              w_final_beat;
    logic [ROW_W-1:0]  w_row_after;

    // SIZE is a power of two, so the natural ROW_W-bit overflow is the wrap to row 0.
    assign w_row_inc    = r_row + ROW_ONE;
    assign w_row_wrap   = (r_row == LAST_ROW);
    assign w_pe_valid   = (r_state == S_RUN);
    assign w_fire       = w_pe_valid & pe_ready;
    assign w_last_row   = w_pe_valid & w_row_wrap;
    // RUN is only entered with r_passes >= 1, so r_passes-1 cannot underflow here.
    assign w_final_beat = w_last_row & (r_pass == (r_passes - PASS_ONE));
    // This is the row the buffer pointer will hold after this edge. An abort
    // uses it to decide whether a drain is still needed.
    assign w_row_after  = w_fire ? w_row_inc : r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_pass    <= '0;
            r_passes  <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_pass    <= w_pass_nxt;
            r_passes  <= w_passes_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_pass_nxt    = r_pass;
        w_passes_nxt  = r_passes;
        w_aborted_nxt = r_aborted;
        w_read_en     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_passes_nxt  = cfg_passes;
                    w_row_nxt     = '0;
                    w_pass_nxt    = '0;
                    w_aborted_nxt = 1'b0;
                    // A zero-pass run issues no reads and completes at once.
                    w_state_nxt   = (cfg_passes == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                w_read_en = w_fire;
                if (w_fire) begin
                    w_row_nxt = w_row_inc;
                    if (w_row_wrap) begin
                        w_pass_nxt = r_pass + PASS_ONE;
                    end
                end
                // A fire on the final beat completes the run. This holds even if
                // abort is raised in the same cycle.
                if (w_fire && w_final_beat) begin
                    w_aborted_nxt = 1'b0;
                    w_state_nxt   = S_DONE;
                end else if (abort) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = (w_row_after == '0) ? S_DONE : S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Step the buffer pointer forward until it reaches row 0 again.
                w_read_en = 1'b1;
                w_row_nxt = w_row_inc;
                if (w_row_wrap) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pe_valid    = w_pe_valid;
    assign buf_read_en = w_read_en;
    assign row_idx     = r_row;
    assign pass_idx    = r_pass;
    assign first_row   = w_pe_valid & (r_row == '0);
    assign last_row    = w_last_row;
    assign final_beat  = w_final_beat;
    assign busy        = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign aborted     = (r_state == S_DONE) & r_aborted;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mu_buffer_sequencer.sv
module tb_mu_buffer_sequencer;

  localparam int SIZE   = 8;
  localparam int ROW_W  = 3;
  localparam int PASS_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic              abort = 1'b0;
  logic              pe_ready = 1'b0;
  logic              pe_valid;
  logic              buf_read_en;
  logic [ROW_W-1:0]  row_idx;
  logic [PASS_W-1:0] pass_idx;
  logic              first_row;
  logic              last_row;
  logic              final_beat;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [1:0]        dbg_state;

  mu_buffer_sequencer #(.SIZE(SIZE), .ROW_W(ROW_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes),
    .abort(abort), .pe_ready(pe_ready), .pe_valid(pe_valid),
    .buf_read_en(buf_read_en), .row_idx(row_idx), .pass_idx(pass_idx),
    .first_row(first_row), .last_row(last_row), .final_beat(final_beat),
    .busy(busy), .done(done), .aborted(aborted), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural mu buffer (shares rst) ----------------
  logic [15:0]      buf_mem [SIZE];
  logic [ROW_W-1:0] buf_rd_ptr;
  logic [15:0]      buf_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_rd_ptr <= '0;
    else if (buf_read_en) buf_rd_ptr <= buf_rd_ptr + 3'd1;
  end
  assign buf_dout = buf_mem[buf_rd_ptr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  bit mon_en   = 1'b0;

  // beat record: {row[2:0], pass[7:0], first, last, final}
  logic [13:0] exp_q[$];
  // completion record: {aborted, read_en count[30:0]}
  logic [31:0] exp_done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: samples on the falling edge, pops expectations when the DUT presents them
  always @(negedge clk) begin
    logic [13:0] eb;
    logic [31:0] ed;
    if (mon_en && !rst) begin
      check("row_vs_buf_ptr", 32'(row_idx), 32'(buf_rd_ptr));
      if (buf_read_en) rd_cnt++;
      if (pe_valid && pe_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got row %0d pass %0d expected no beat", row_idx, pass_idx);
        end else begin
          eb = exp_q.pop_front();
          check("beat_fields", 32'({row_idx, pass_idx, first_row, last_row, final_beat}), 32'(eb));
          check("beat_data", 32'(buf_dout), 32'(buf_mem[eb[13:11]]));
        end
      end
      if (done) begin
        check("done_not_busy", 32'(busy), 32'd0);
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          ed = exp_done_q.pop_front();
          check("done_aborted_reads", {aborted, 31'(rd_cnt)}, ed);
        end
        rd_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // mode: 0 = pe_ready always 1, 1 = alternating 1,0, 2 = random
  // do_ab: abort after k beats have been consumed; coinc = the k-th beat fires with abort
  task automatic run_case(input int p, input bit do_ab, input int k, input bit coinc, input int mode);
    int n, reads, beats, cyc;
    bit ab_sent, fin, saw_busy;
    logic [13:0] b;
    n = do_ab ? k : p * SIZE;
    for (int i = 0; i < n; i++) begin
      b = {3'(i % SIZE), 8'(i / SIZE), (i % SIZE == 0), (i % SIZE == SIZE - 1), (i == p * SIZE - 1)};
      exp_q.push_back(b);
    end
    // after an abort the pointer is drained up to the next multiple of SIZE
    reads = do_ab ? ((k + SIZE - 1) / SIZE) * SIZE : p * SIZE;
    exp_done_q.push_back({(do_ab && (k < p * SIZE)), 31'(reads)});

    start = 1'b1;
    cfg_passes = PASS_W'(p);
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0; cyc = 0; fin = 0; ab_sent = 0; saw_busy = 0;
    while (!fin && cyc < 1000) begin
      abort = 1'b0;
      if (do_ab && !ab_sent && beats == (coinc ? k - 1 : k)) begin
        abort = 1'b1;
        pe_ready = coinc;
        ab_sent = 1'b1;
      end else begin
        case (mode)
          0: pe_ready = 1'b1;
          1: pe_ready = (cyc % 2 == 0);
          default: pe_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
      #3;
      if (pe_valid && pe_ready) beats++;
      if (busy) saw_busy = 1'b1;
      if (done) fin = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0;
    pe_ready = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: got no done expected done within 1000 cycles (passes=%0d)", p);
    end else begin
      check("row_after_done", 32'(row_idx), 32'd0);
    end
    if (p == 0) check("busy_never_zero_pass", 32'(saw_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("dones_left", 32'(exp_done_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p, k, cnt;
    bit ab, co;
    for (int i = 0; i < SIZE; i++) buf_mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({pe_valid, buf_read_en, row_idx, pass_idx, first_row, last_row,
               final_beat, busy, done, aborted}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_case(2, 1'b0, 0, 1'b0, 0);   // two passes, always ready
    run_case(1, 1'b0, 0, 1'b0, 1);   // alternating ready
    run_case(3, 1'b1, 3, 1'b0, 0);   // abort at row 3 with ready low -> drain 5
    run_case(0, 1'b0, 0, 1'b0, 0);   // zero passes
    run_case(2, 1'b1, 8, 1'b1, 0);   // abort with fire at row 7 of pass 0
    run_case(2, 1'b1, 16, 1'b1, 0);  // abort on final beat -> not aborted
    run_case(2, 1'b1, 0, 1'b0, 2);   // abort on the very first RUN cycle

    // asynchronous reset in the middle of a run
    mon_en = 1'b0;
    start = 1'b1;
    cfg_passes = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    pe_ready = 1'b1;
    cnt = 0;
    while (row_idx != 3'd5 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("reached_row5", 32'(row_idx), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_run_reset_outputs",
          32'({pe_valid, buf_read_en, row_idx, pass_idx, first_row, last_row,
               final_beat, busy, done, aborted}), 32'd0);
    pe_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    rd_cnt = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_case(1, 1'b0, 0, 1'b0, 0);

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      p = $urandom_range(0, 3);
      ab = (p != 0) && ($urandom_range(0, 1) == 1);
      co = ($urandom_range(0, 1) == 1);
      k = 0;
      if (ab) k = co ? $urandom_range(1, p * SIZE) : $urandom_range(0, p * SIZE - 1);
      run_case(p, ab, k, co, 2);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
